// File: rtl/game_pkg.sv
// Shared constants and types for the wall/game logic.
// Holds the screen geometry, wall placement constants, the scroller FSM
// state encoding, the wall slot record and the gap-top mapping helper.
// No ports (package).
package game_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int WALL_W    = 8;
  localparam int MIN_TOP   = 10;
  localparam int BIRD_X    = 30;
  localparam int SPACING   = 40;
  localparam int NUM_WALLS = 4;

  // Scroller FSM state encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_MOVE      = 2'd1;
  localparam logic [1:0] ST_SPAWN_REQ = 2'd2;
  localparam logic [1:0] ST_SPAWN_WR  = 2'd3;

  typedef struct packed {
    logic       active;
    logic [7:0] x;
    logic [7:0] top;
  } wall_t;

  // Five random bits doubled give an even gap top in MIN_TOP..MIN_TOP+62.
  function automatic logic [7:0] gap_top_of(input logic [4:0] h);
    return 8'(MIN_TOP) + {2'b00, h, 1'b0};
  endfunction

endpackage

// File: rtl/wall_slot_alloc.sv
// Lowest-free-slot priority encoder for the wall pool.
// Ports:
//   active   - in,  one bit per slot, 1 = slot holds a live wall
//   idx      - out, index of the lowest-numbered free slot (0 if none)
//   any_free - out, 1 when at least one slot is free
module wall_slot_alloc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  active,
  output logic [IW-1:0] idx,
  output logic          any_free
);

  // Scan from the top down so the last hit is the lowest free index.
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!active[i]) begin
        idx      = IW'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wall_scroller.sv
// Wall pool manager: pulls random heights from the height generator with a
// req/valid handshake, spawns walls at the right screen edge every SPACING
// frames, scrolls live walls left one pixel per frame and flags each wall
// as it clears the bird column.
// Ports:
//   clk, resetn              - clock, synchronous active-low reset
//   enable                   - game running; frame ticks ignored when low
//   frame_tick               - one-cycle pulse per frame
//   height_in, height_valid  - random height from the generator
//   height_req               - request for a new height
//   rd_idx -> rd_x, rd_top, rd_active - combinational slot read port
//   wall_passed              - one-cycle pulse when a wall clears BIRD_X
//   spawn_count              - walls spawned since reset (wraps)
module wall_scroller #(
  parameter int NUM_WALLS = game_pkg::NUM_WALLS,
  parameter int SCREEN_W  = game_pkg::SCREEN_W,
  parameter int WALL_W    = game_pkg::WALL_W,
  parameter int SPACING   = game_pkg::SPACING,
  parameter int MIN_TOP   = game_pkg::MIN_TOP,
  parameter int BIRD_X    = game_pkg::BIRD_X
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [7:0] height_in,
  input  logic       height_valid,
  output logic       height_req,
  input  logic [1:0] rd_idx,
  output logic [7:0] rd_x,
  output logic [7:0] rd_top,
  output logic       rd_active,
  output logic       wall_passed,
  output logic [7:0] spawn_count
);
  import game_pkg::ST_IDLE;
  import game_pkg::ST_MOVE;
  import game_pkg::ST_SPAWN_REQ;
  import game_pkg::ST_SPAWN_WR;
  import game_pkg::wall_t;

  localparam int IW = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
  localparam logic [7:0] SPACING_V = 8'(SPACING);
  // Old x that lands the wall's right edge on the bird column after the step.
  localparam logic [7:0] PASS_X    = 8'(BIRD_X - WALL_W + 1);

  logic [1:0] state_reg;
  logic       pending_reg;
  logic [7:0] dist_reg;
  logic [7:0] gap_top_reg;
  logic       passed_reg;
  logic [7:0] count_reg;

  logic [NUM_WALLS-1:0]      active_w;
  logic [NUM_WALLS-1:0][7:0] x_w;
  logic [NUM_WALLS-1:0][7:0] top_w;
  logic [NUM_WALLS-1:0]      free_after_move;
  logic [NUM_WALLS-1:0]      pass_hit;

  logic [IW-1:0] alloc_idx;
  logic          alloc_any_free;
  logic          spawn_we;
  logic [7:0]    dist_next;
  logic [7:0]    cap_top;
  logic          unused_height;

  assign unused_height = ^height_in[7:5];
  assign cap_top       = MIN_TOP[7:0] + {2'b00, height_in[4:0], 1'b0};
  assign dist_next     = (dist_reg >= SPACING_V) ? SPACING_V : dist_reg + 8'd1;
  assign spawn_we      = (state_reg == ST_SPAWN_WR) && alloc_any_free;

  wall_slot_alloc #(.N(NUM_WALLS), .IW(IW)) u_alloc (
    .active   (active_w),
    .idx      (alloc_idx),
    .any_free (alloc_any_free)
  );

  for (genvar gi = 0; gi < NUM_WALLS; gi++) begin : g_slot
    wall_t slot_reg;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        slot_reg <= '0;
      end else if (state_reg == ST_MOVE && slot_reg.active) begin
        if (slot_reg.x == 8'd0) slot_reg <= '0;   // retire off the left edge
        else                    slot_reg.x <= slot_reg.x - 8'd1;
      end else if (spawn_we && alloc_idx == IW'(gi)) begin
        slot_reg <= '{active: 1'b1, x: 8'(SCREEN_W), top: gap_top_reg};
      end
    end

    assign active_w[gi]        = slot_reg.active;
    assign x_w[gi]             = slot_reg.x;
    assign top_w[gi]           = slot_reg.top;
    assign free_after_move[gi] = !slot_reg.active || (slot_reg.x == 8'd0);
    assign pass_hit[gi]        = slot_reg.active && (slot_reg.x == PASS_X);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= ST_IDLE;
      pending_reg <= 1'b0;
      dist_reg    <= SPACING_V;
      gap_top_reg <= 8'd0;
      passed_reg  <= 1'b0;
      count_reg   <= 8'd0;
    end else begin
      passed_reg <= 1'b0;
      // Ticks that land while busy are remembered once; extras are dropped.
      if (enable && frame_tick && state_reg != ST_IDLE) pending_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (enable && (frame_tick || pending_reg)) begin
            state_reg   <= ST_MOVE;
            pending_reg <= 1'b0;
          end
        end
        ST_MOVE: begin
          dist_reg   <= dist_next;
          passed_reg <= |pass_hit;   // several walls at once still give one pulse
          state_reg  <= (dist_next == SPACING_V && |free_after_move) ? ST_SPAWN_REQ : ST_IDLE;
        end
        ST_SPAWN_REQ: begin
          if (height_valid) begin
            gap_top_reg <= cap_top;
            state_reg   <= ST_SPAWN_WR;
          end
        end
        default: begin
          if (alloc_any_free) begin
            dist_reg  <= 8'd0;
            count_reg <= count_reg + 8'd1;
          end
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign height_req  = (state_reg == ST_SPAWN_REQ);
  assign wall_passed = passed_reg;
  assign spawn_count = count_reg;
  assign rd_active   = active_w[rd_idx];
  assign rd_x        = active_w[rd_idx] ? x_w[rd_idx] : 8'd0;
  assign rd_top      = active_w[rd_idx] ? top_w[rd_idx] : 8'd0;

endmodule
